// File: rtl/dff_mon_pkg.sv
// Shared types and counter arithmetic for the flop-pair edge monitor.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package dff_mon_pkg;

  // Default counter width, and the widest counter the generic helper supports
  localparam int CNT_W_DEF = 8;
  localparam int CNT_W_MAX = 32;

  typedef logic [CNT_W_DEF-1:0] cnt_t;
  typedef logic [CNT_W_MAX-1:0] cnt_wide_t;

  // Increment a w-bit value held zero-extended in a wide word.
  // At all-ones it either holds (sat_en=1) or wraps to zero (sat_en=0).
  function automatic cnt_wide_t sat_inc_w(cnt_wide_t v, bit sat_en, int unsigned w);
    cnt_wide_t top_v;
    top_v = cnt_wide_t'({CNT_W_MAX{1'b1}}) >> (CNT_W_MAX - w);
    if (v == top_v) begin
      return sat_en ? v : '0;
    end
    return v + cnt_wide_t'(1);
  endfunction

  // Same operation at the default counter width
  function automatic cnt_t sat_inc(cnt_t v, bit sat_en);
    return cnt_t'(sat_inc_w(cnt_wide_t'(v), sat_en, CNT_W_DEF));
  endfunction

endpackage

// File: rtl/edge_counter.sv
// Event counter with synchronous clear that beats increment; saturates or wraps.
// Latency: count reflects inc/clr one cycle after the sampling edge.
// Backpressure: none; an increment is taken on every cycle inc is high.
module edge_counter
  import dff_mon_pkg::*;
#(
  parameter int W      = CNT_W_DEF,
  parameter bit SAT_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear has priority, otherwise step by one at the chosen overflow policy
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = W'(sat_inc_w(cnt_wide_t'(count_q), SAT_EN, W));
    end
  end

  // Count register, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/dff_edge_monitor.sv
// Watches a flop's (q, qbar) pair: edge pulses, edge counts, pair-error flag/sticky/count.
// Latency: every output is registered, one cycle after the sampling edge.
// Backpressure: none; inputs are sampled every cycle.
module dff_edge_monitor
  import dff_mon_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter bit SAT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             q_in,
  input  logic             qbar_in,
  input  logic             clr,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic             pair_err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt
);

  // prev_q resets to 0 to match the upstream flop's reset value
  logic prev_q;
  logic rise_q,       rise_d;
  logic fall_q,       fall_d;
  logic pair_err_q,   pair_err_d;
  logic err_sticky_q, err_sticky_d;

  // Edge detection looks at q only; qbar feeds the error path alone.
  // A fresh error wins over a coincident clear for the sticky bit.
  always_comb begin
    rise_d       = q_in & ~prev_q;
    fall_d       = ~q_in & prev_q;
    pair_err_d   = (q_in == qbar_in);
    err_sticky_d = err_sticky_q;
    if (pair_err_d) begin
      err_sticky_d = 1'b1;
    end else if (clr) begin
      err_sticky_d = 1'b0;
    end
  end

  // Pulse, flag and history registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_q       <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      pair_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      prev_q       <= q_in;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      pair_err_q   <= pair_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  edge_counter #(.W(CNT_W), .SAT_EN(SAT_EN)) u_rise_cnt (
    .clk(clk), .rstn(rstn), .inc(rise_d), .clr(clr), .count(rise_cnt)
  );

  edge_counter #(.W(CNT_W), .SAT_EN(SAT_EN)) u_fall_cnt (
    .clr(clr), .clk(clk), .rstn(rstn), .inc(fall_d), .count(fall_cnt)
  );

  edge_counter #(.W(CNT_W), .SAT_EN(SAT_EN)) u_err_cnt (
    .clk(clk), .rstn(rstn), .inc(pair_err_d), .clr(clr), .count(err_cnt)
  );

  assign rise       = rise_q;
  assign fall       = fall_q;
  assign pair_err   = pair_err_q;
  assign err_sticky = err_sticky_q;

  // History for the monotonic-count check: counts one cycle back and the clear that produced them
  logic [CNT_W-1:0] mon_rise_q;
  logic [CNT_W-1:0] mon_fall_q;
  logic [CNT_W-1:0] mon_err_q;
  logic             mon_clr_q;

  // Capture the current counts and clear for comparison on the next edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mon_rise_q <= '0;
      mon_fall_q <= '0;
      mon_err_q  <= '0;
      mon_clr_q  <= 1'b0;
    end else begin
      mon_rise_q <= rise_cnt;
      mon_fall_q <= fall_cnt;
      mon_err_q  <= err_cnt;
      mon_clr_q  <= clr;
    end
  end

  // Output consistency checks; values read here are those registered on the previous edge
  always @(posedge clk) begin
    if (rstn) begin
      a_excl: assert (!(rise_q && fall_q))
        $info("%0t A_EXCL ok", $time);
      else
        $error("%0t A_EXCL: rise and fall high together", $time);
      a_sticky: assert (!pair_err_q || err_sticky_q)
        $info("%0t A_STICKY ok", $time);
      else
        $error("%0t A_STICKY: pair_err without err_sticky", $time);
      if (SAT_EN) begin
        a_sat: assert (mon_clr_q || ((rise_cnt >= mon_rise_q) && (fall_cnt >= mon_fall_q) &&
                                     (err_cnt >= mon_err_q)))
          $info("%0t A_SAT ok", $time);
        else
          $error("%0t A_SAT: saturating counter decreased", $time);
      end
    end
  end

endmodule

// File: doc/dff_edge_monitor.md
Name: dff_edge_monitor

Overview:
- Downstream consumer of the flop stage's complementary outputs (q, qbar).
- Registers the pair, emits one-cycle rise/fall pulses and keeps saturating edge counts.
- Flags any cycle where the pair is not complementary, with a sticky error and an error count.
- Carries its own immediate assertions on output consistency, in the same style as the flop stage's checks.

Parameters:
- CNT_W, 8, width of rise_cnt, fall_cnt and err_cnt.
- SAT_EN, 1, 1 = counters saturate at 2^CNT_W-1; 0 = counters wrap to 0.

Ports:
- clk  input  1  rising-edge clock, same domain as the flop stage.
- rstn  input  1  asynchronous active-low reset.
- q_in  input  1  true output of the upstream flop.
- qbar_in  input  1  complement output of the upstream flop.
- clr  input  1  synchronous clear of counters and sticky error.
- rise  output  1  one-cycle pulse: q_in rose.
- fall  output  1  one-cycle pulse: q_in fell.
- rise_cnt  output  CNT_W  number of rising edges seen.
- fall_cnt  output  CNT_W  number of falling edges seen.
- pair_err  output  1  registered: last sample had q_in == qbar_in.
- err_sticky  output  1  pair_err has occurred since reset/clr.
- err_cnt  output  CNT_W  number of error samples.

Behaviour:
- Reset (rstn low, asynchronous, takes effect immediately and also mid-operation):
  - rise, fall, pair_err, err_sticky = 0.
  - All counters = 0.
  - Internal prev_q = 0, matching the flop's reset value q=0.
- Sampling: every posedge clk samples q_in/qbar_in; all outputs are registered, latency 1 cycle.
- Edge detect at posedge n:
  - rise = q_in & ~prev_q.
  - fall = ~q_in & prev_q.
  - prev_q <= q_in.
  - Outputs visible in cycle n+1 and high for exactly one cycle per edge.
- First sample after reset release:
  - prev_q=0, so q_in=1 produces rise.
  - q_in=0 produces nothing.
- Edge detection uses q_in only; qbar_in affects only the error path.
- pair_err at posedge n = (q_in == qbar_in); it is independent of edge detection.
- Counters:
  - Increment by 1 on the same posedge that sets the corresponding pulse/pair_err.
  - SAT_EN=1: hold at all-ones. SAT_EN=0: all-ones + 1 = 0.
- clr:
  - Sampled at posedge.
  - Zeroes all three counters and err_sticky.
  - clr beats an increment in the same cycle: counter becomes 0, not 1.
  - rise/fall/pair_err pulses still generated that cycle.
- err_sticky:
  - Set on any pair_err sample.
  - If clr and an error sample coincide, set wins (err_sticky=1), err_cnt=0.
- Toggle every cycle:
  - Alternating rise/fall pulses each cycle.
  - rise and fall are never simultaneously high.
- Embedded immediate assertions in an always @(posedge clk) block, pass/fail via $info/$error with $time:
  - A_EXCL: !(rise && fall).
  - A_STICKY: pair_err implies err_sticky in the same cycle.
  - A_SAT: with SAT_EN=1, a counter never decreases except on clr or reset.

Decomposition:
- Package dff_mon_pkg:
  - CNT_W default constant.
  - typedef cnt_t = logic [CNT_W-1:0].
  - Function sat_inc(cnt_t, bit sat_en).
- One sub-module, edge_counter:
  - Ports: clk, rstn, inc, clr, count.
  - Implements clr-priority and saturate/wrap.
  - Instantiated three times (rise, fall, err).

Test Plan:
- Reset with q_in=0, qbar_in=1 held 3 cycles, then release -> all outputs 0, no rise/fall after release.
- q_in sequence 0,1,1,0,1 (qbar_in = ~q_in) -> rise in cycles 2 and 5, fall in cycle 4, rise_cnt=2, fall_cnt=1, pair_err never set.
- Force q_in=qbar_in=1 for 2 cycles -> pair_err high 2 cycles, err_cnt=2, err_sticky=1 and stays 1 after the pair recovers.
- CNT_W=3, SAT_EN=1: 10 rising edges -> rise_cnt stops at 7. Repeat with SAT_EN=0 -> rise_cnt=2.
- clr asserted on the same posedge as a rising edge and an error sample -> rise pulses, rise_cnt=0, err_cnt=0, err_sticky=1.
- rstn dropped mid-stream with rise_cnt=5, asynchronously between clock edges -> all outputs 0 immediately, before the next posedge. On release with q_in=1 -> rise on first sample.
